// File: rtl/hex_char_writer.sv
// hex_char_writer: streams a captured word as a row of hex characters into the text buffer.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (the last digit is always shown).
module hex_char_writer #(
    parameter int NIBBLES   = 8,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [31:0]       val_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        nib_o,
    input  logic [15:0]       char_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [15:0]       wr_data_o,
    input  logic              wr_ready_i
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] shift;
    logic [3:0] cnt;
    logic fire, last, capture, blank;
    assign capture = state == IDLE && start_i;
    assign fire = state == WRITE && wr_ready_i;
    assign last = cnt == 4'(NIBBLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = state == IDLE  ? (start_i ? WRITE : IDLE) :
                   state == WRITE ? (fire && last ? DONE : WRITE) : IDLE;
    // Left-align the captured digits so the current one is always shift[31:28].
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shift <= '0;
            cnt   <= '0;
        end else if (capture) begin
            shift <= val_i << (32 - 4 * NIBBLES);
            cnt   <= '0;
        end else if (fire) begin
            shift <= shift << 4;
            cnt   <= cnt + 4'd1;
        end
`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) seen <= 1'b0;
        else if (capture) seen <= 1'b0;
        else if (fire && nib_o != 4'd0) seen <= 1'b1;
    assign blank = state == WRITE && !seen && nib_o == 4'd0 && !last;
`else
    assign blank = 1'b0;
`endif
    always_comb begin
        busy_o    = state == WRITE;
        done_o    = state == DONE;
        wr_en_o   = state == WRITE;
        wr_addr_o = state == WRITE ? ADDR_W'(BASE_ADDR) + ADDR_W'(cnt) : '0;
        nib_o     = shift[31:28];
        wr_data_o = blank ? 16'hFF20 : char_i;
    end
endmodule

// File: tb/tb_hex_char_writer.sv
// tb_hex_char_writer: randomized self-checking bench with a digit-list reference model.
// Two instances: default geometry, and a 4-digit row at BASE_ADDR=62 that wraps the address.
module tb_hex_char_writer;
    logic clk = 0, rst_n = 0, start = 0, ready = 0;
    logic [31:0] val = 0;
    logic busy, done, wr_en;
    logic [3:0] nib;
    logic [15:0] chr, wr_data;
    logic [5:0] wr_addr;
    logic start_b = 0, ready_b = 1;
    logic [31:0] val_b = 0;
    logic busy_b, done_b, wr_en_b;
    logic [3:0] nib_b;
    logic [15:0] chr_b, wr_data_b;
    logic [5:0] wr_addr_b;
    int total = 0, bad = 0;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] n);
        return n < 4'd10 ? 16'hFF30 + 16'(n) : 16'hFF37 + 16'(n);
    endfunction

    assign chr   = enc(nib);
    assign chr_b = enc(nib_b);

    hex_char_writer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .val_i(val), .busy_o(busy), .done_o(done),
        .nib_o(nib), .char_i(chr), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_ready_i(ready)
    );

    hex_char_writer #(.NIBBLES(4), .ADDR_W(6), .BASE_ADDR(62)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .val_i(val_b), .busy_o(busy_b), .done_o(done_b),
        .nib_o(nib_b), .char_i(chr_b), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .wr_ready_i(ready_b)
    );

    // Expected characters of a row, MSB digit first.
    task automatic expect_row(input logic [31:0] v, input int n, output logic [15:0] d [8]);
        bit seen = 0;
        logic [3:0] nb;
        for (int k = 0; k < 8; k++) d[k] = 16'h0;
        for (int k = 0; k < n; k++) begin
            nb = v[4*(n-1-k) +: 4];
            if (nb != 4'd0) seen = 1;
            d[k] = (LZB && !seen && k != n - 1) ? 16'hFF20 : enc(nb);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        total++;
        if ({busy, done, wr_en, wr_addr, nib} !== 13'h0) begin
            bad++;
            $display("FAIL reset_a: got %h want 0", {busy, done, wr_en, wr_addr, nib});
        end
        total++;
        if ({busy_b, done_b, wr_en_b, wr_addr_b, nib_b} !== 13'h0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0", {busy_b, done_b, wr_en_b, wr_addr_b, nib_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // rnd: random ready; otherwise ready drops for stall_len cycles on write stall_at.
    // poke: re-request with all-ones while busy, which must be ignored.
    task automatic run_row(input logic [31:0] v, input int stall_at, input int stall_len,
                           input bit rnd, input bit poke);
        logic [15:0] d [8];
        int k = 0, stalls = 0;
        bit got_done = 0;
        expect_row(v, 8, d);
        @(negedge clk);
        val = v;
        start = 1;
        @(negedge clk);
        start = 0;
        val = $urandom;
        for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
            if (poke && cyc == 2) begin start = 1; val = 32'hFFFF_FFFF; end
            if (poke && cyc == 3) start = 0;
            if (done) begin
                got_done = 1;
                total += 3;
                if (cyc != 9 + stalls) begin
                    bad++;
                    $display("FAIL done_cycle: got %0d want %0d", cyc, 9 + stalls);
                end
                if (k != 8) begin bad++; $display("FAIL write_count: got %0d want 8", k); end
                if (busy !== 1'b0 || wr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL done_outputs: busy=%b wr_en=%b want 0 0", busy, wr_en);
                end
            end else begin
                total += 3;
                if (wr_en !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL write_en: wr_en=%b busy=%b want 1 1 (cycle %0d)", wr_en, busy, cyc);
                end
                if (wr_addr !== 6'(k)) begin
                    bad++;
                    $display("FAIL addr: got %0d want %0d", wr_addr, k);
                end
                if (wr_data !== d[k & 7]) begin
                    bad++;
                    $display("FAIL data[%0d]: got %h want %h", k, wr_data, d[k & 7]);
                end
                ready = rnd ? 1'($urandom) : !(k == stall_at && stalls < stall_len);
                if (ready) k++;
                else stalls++;
            end
            @(negedge clk);
        end
        total++;
        if (!got_done) begin bad++; $display("FAIL done_timeout: got none want pulse"); end
        total++;
        if ({done, busy, wr_en} !== 3'b000) begin
            bad++;
            $display("FAIL after_done: got %b want 000", {done, busy, wr_en});
        end
        ready = 0;
    endtask

    task automatic test_abort();
        @(negedge clk);
        val = $urandom;
        start = 1;
        ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        total++;
        if (wr_addr !== 6'd3) begin bad++; $display("FAIL abort_pos: got %0d want 3", wr_addr); end
        #2 rst_n = 0;
        #1;
        total++;
        if ({busy, done, wr_en, wr_addr, nib} !== 13'h0) begin
            bad++;
            $display("FAIL abort_async: got %h want 0", {busy, done, wr_en, wr_addr, nib});
        end
        @(negedge clk);
        rst_n = 1;
        ready = 0;
        total++;
        if (wr_en !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", wr_en); end
        run_row($urandom, -1, 0, 1, 0);
    endtask

    task automatic test_wrap(input logic [31:0] v);
        logic [15:0] d [8];
        expect_row(v, 4, d);
        @(negedge clk);
        val_b = v;
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        val_b = $urandom;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            total += 2;
            if (done_b !== (cyc == 5)) begin
                bad++;
                $display("FAIL wrap_done[%0d]: got %b want %b", cyc, done_b, cyc == 5);
            end
            if (wr_en_b !== (cyc <= 4)) begin
                bad++;
                $display("FAIL wrap_en[%0d]: got %b want %b", cyc, wr_en_b, cyc <= 4);
            end
            if (cyc <= 4) begin
                total += 2;
                if (wr_addr_b !== 6'(61 + cyc)) begin
                    bad++;
                    $display("FAIL wrap_addr[%0d]: got %0d want %0d", cyc, wr_addr_b, 6'(61 + cyc));
                end
                if (wr_data_b !== d[cyc-1]) begin
                    bad++;
                    $display("FAIL wrap_data[%0d]: got %h want %h", cyc, wr_data_b, d[cyc-1]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_row(32'h0040_1A3C, -1, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_row(32'h0040_1A3C, 2, 3, 0, 0);
    endtask

    task automatic test_ignore_start();
        run_row(32'h0040_1A3C, -1, 0, 0, 1);
    endtask

    task automatic test_leading_zero();
        run_row(32'h0000_0000, -1, 0, 0, 0);
        run_row(32'h0000_1A3C, -1, 0, 1, 0);
    endtask

    task automatic test_random();
        repeat (8) run_row($urandom >> $urandom_range(0, 31), -1, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore_start();
        test_abort();
        test_wrap(32'h0000_BEEF);
        test_wrap($urandom);
        test_leading_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
